// File: rtl/edge_detector_array.sv
// Multi-channel edge detector: each channel is synchronised, debounced and classified
// against a per-channel mode; it then drives a pulse, a sticky flag and a saturating counter.
module edge_detector_array #(
   parameter int   N_CH        = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   DB_W        = 4,
   parameter int   CNT_W       = 8,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         sig_in,
   input  logic [2*N_CH-1:0]       mode,
   input  logic [DB_W-1:0]         db_len,
   input  logic                    clr_flags,
   input  logic                    clr_count,
   output logic [N_CH-1:0]         stable,
   output logic [N_CH-1:0]         edge_pulse,
   output logic [N_CH-1:0]         flag,
   output logic [N_CH*CNT_W-1:0]   event_cnt,
   output logic                    any_event
);

   logic [N_CH-1:0] w_qual;
   logic            r_any_event;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] r_sync;
         logic [DB_W-1:0]        r_db_cnt;
         logic                   r_stable;
         logic                   r_pulse;
         logic                   r_flag;
         logic [CNT_W-1:0]       r_cnt;
         logic                   w_s;
         logic                   w_commit;

         assign w_s      = r_sync[SYNC_STAGES-1];
         // The stable level flips only after the synced level has disagreed for D+1 edges.
         assign w_commit = (w_s != r_stable) && (r_db_cnt == db_len);
         assign w_qual[gi] = (w_commit &  w_s & mode[2*gi]) |
                             (w_commit & ~w_s & mode[2*gi+1]);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync   <= {SYNC_STAGES{IDLE_LEVEL}};
               r_stable <= IDLE_LEVEL;
               r_db_cnt <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[gi]};
               if (w_s == r_stable) begin
                  r_db_cnt <= '0;
               end else if (w_commit) begin
                  r_stable <= w_s;
                  r_db_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + DB_W'(1);
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_pulse <= 1'b0;
               r_flag  <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_pulse <= w_qual[gi];
               // A coincident edge wins over the clear so the event is never lost.
               r_flag  <= (r_flag & ~clr_flags) | w_qual[gi];
               if (clr_count)
                  r_cnt <= '0;
               else if (w_qual[gi] && (r_cnt != {CNT_W{1'b1}}))
                  r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         assign stable[gi]                       = r_stable;
         assign edge_pulse[gi]                   = r_pulse;
         assign flag[gi]                         = r_flag;
         assign event_cnt[gi*CNT_W +: CNT_W]     = r_cnt;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_any_event <= 1'b0;
      else
         r_any_event <= |w_qual;
   end

   assign any_event = r_any_event;

endmodule

// File: tb/tb_edge_detector_array.sv
// Directed bench for edge_detector_array: debounce timing, glitch rejection,
// saturation, flag/count clear priority and asynchronous reset abort.
module tb_edge_detector_array;
   localparam int N_CH  = 4;
   localparam int CNT_W = 8;

   logic                  clk;
   logic                  reset;
   logic [N_CH-1:0]       sig_in;
   logic [2*N_CH-1:0]     mode;
   logic [3:0]            db_len;
   logic                  clr_flags;
   logic                  clr_count;
   logic [N_CH-1:0]       stable;
   logic [N_CH-1:0]       edge_pulse;
   logic [N_CH-1:0]       flag;
   logic [N_CH*CNT_W-1:0] event_cnt;
   logic                  any_event;

   int n_total = 0;
   int n_bad   = 0;
   int pulse_cnt [N_CH];
   int any_mismatch = 0;
   int st1_dropped  = 0;
   int base_pulses;

   edge_detector_array #(
      .N_CH(N_CH), .SYNC_STAGES(2), .DB_W(4), .CNT_W(CNT_W), .IDLE_LEVEL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .db_len(db_len),
      .clr_flags(clr_flags), .clr_count(clr_count), .stable(stable),
      .edge_pulse(edge_pulse), .flag(flag), .event_cnt(event_cnt), .any_event(any_event)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses are exactly one cycle wide, so sampling on the falling edge counts each once.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++)
            if (edge_pulse[i]) pulse_cnt[i]++;
         if (any_event !== (|edge_pulse)) any_mismatch++;
         if (stable[1] !== 1'b1) st1_dropped++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   function automatic int total_pulses();
      int s = 0;
      for (int i = 0; i < N_CH; i++) s += pulse_cnt[i];
      return s;
   endfunction

   initial begin
      for (int i = 0; i < N_CH; i++) pulse_cnt[i] = 0;
      reset = 1'b1; sig_in = 4'hF; mode = '0; db_len = '0;
      clr_flags = 1'b0; clr_count = 1'b0;
      repeat (3) tick();
      check_val("rst_stable", 32'(stable), 32'hF);
      check_val("rst_pulse",  32'(edge_pulse), 32'h0);
      check_val("rst_flag",   32'(flag), 32'h0);
      check_val("rst_cnt",    event_cnt, 32'h0);
      check_val("rst_any",    32'(any_event), 32'h0);
      reset = 1'b0;
      repeat (6) tick();
      check_val("idle_no_edge", 32'(total_pulses()), 32'd0);

      // Ch0 falling edge with D=3: stable falls on the 6th edge.
      mode[1:0] = 2'b10; db_len = 4'd3; sig_in[0] = 1'b0;
      repeat (5) tick();
      check_val("c0_stable_e5", 32'(stable[0]), 32'd1);
      check_val("c0_pulse_e5",  32'(edge_pulse), 32'h0);
      tick();
      check_val("c0_stable_e6", 32'(stable[0]), 32'd0);
      check_val("c0_pulse_e6",  32'(edge_pulse), 32'h1);
      check_val("c0_any_e6",    32'(any_event), 32'd1);
      tick();
      check_val("c0_pulse_e7",  32'(edge_pulse), 32'h0);
      check_val("c0_any_e7",    32'(any_event), 32'd0);
      check_val("c0_cnt",       32'(event_cnt[7:0]), 32'd1);
      check_val("c0_flag",      32'(flag), 32'h1);

      // Ch1 three-cycle glitch with D=3 is rejected.
      mode[3:2] = 2'b10; sig_in[1] = 1'b0;
      repeat (3) tick();
      sig_in[1] = 1'b1;
      repeat (10) tick();
      check_val("c1_glitch_stable", 32'(st1_dropped), 32'd0);
      check_val("c1_glitch_pulse",  32'(pulse_cnt[1]), 32'd0);
      check_val("c1_glitch_cnt",    32'(event_cnt[15:8]), 32'd0);

      // Ch2 both edges, D=0, 300 toggles: counter saturates at 255.
      mode[5:4] = 2'b11; db_len = 4'd0;
      for (int j = 0; j < 300; j++) begin
         sig_in[2] = ~sig_in[2];
         repeat (4) tick();
         if (j == 99) check_val("c2_cnt_100", 32'(event_cnt[23:16]), 32'd100);
      end
      repeat (4) tick();
      check_val("c2_pulses", 32'(pulse_cnt[2]), 32'd300);
      check_val("c2_sat",    32'(event_cnt[23:16]), 32'd255);
      check_val("c2_flag",   32'(flag[2]), 32'd1);

      // Ch3 rise-only: a fall is ignored, a rise coinciding with clr_flags still flags.
      mode[7:6] = 2'b01; db_len = 4'd1; sig_in[3] = 1'b0;
      repeat (8) tick();
      check_val("c3_fall_pulse",  32'(pulse_cnt[3]), 32'd0);
      check_val("c3_fall_stable", 32'(stable[3]), 32'd0);
      check_val("c3_fall_flag",   32'(flag[3]), 32'd0);
      sig_in[3] = 1'b1;
      repeat (3) tick();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check_val("c3_rise_pulse", 32'(edge_pulse), 32'h8);
      check_val("c3_rise_flag",  32'(flag), 32'h8);
      check_val("c3_rise_cnt",   32'(event_cnt[31:24]), 32'd1);

      // Ch0 rise and ch1 fall in the same cycle as clr_count.
      mode[1:0] = 2'b01; mode[3:2] = 2'b10; db_len = 4'd0;
      sig_in[0] = 1'b1; sig_in[1] = 1'b0;
      repeat (2) tick();
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      check_val("dual_pulse", 32'(edge_pulse), 32'h3);
      check_val("dual_any",   32'(any_event), 32'd1);
      check_val("dual_flag",  32'(flag), 32'hB);
      check_val("dual_cnt",   event_cnt, 32'h0);

      // Reset two cycles into a D=5 debounce aborts it.
      mode[1:0] = 2'b11; db_len = 4'd5; sig_in[0] = 1'b0;
      repeat (4) tick();
      #2 reset = 1'b1;
      #1;
      check_val("arst_stable", 32'(stable), 32'hF);
      check_val("arst_pulse",  32'(edge_pulse), 32'h0);
      check_val("arst_flag",   32'(flag), 32'h0);
      check_val("arst_cnt",    event_cnt, 32'h0);
      check_val("arst_any",    32'(any_event), 32'd0);
      sig_in = 4'hF;
      repeat (2) tick();
      reset = 1'b0;
      base_pulses = total_pulses();
      repeat (15) tick();
      check_val("post_rst_pulses", 32'(total_pulses() - base_pulses), 32'd0);
      check_val("post_rst_stable", 32'(stable), 32'hF);
      check_val("any_tracks_pulse", 32'(any_mismatch), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/edge_detector_array.md
EDGE_DETECTOR_ARRAY -- requirements
Module: edge_detector_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (2..4).
REQ-003 Parameter DB_W, default 4: debounce length field width.
REQ-004 Parameter CNT_W, default 8: per-channel event counter width.
REQ-005 Parameter IDLE_LEVEL, default 1: reset value of all synchroniser and stable-level registers.
REQ-006 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sig_in  input  N_CH  asynchronous raw channel inputs, e.g. quarter-step and limit-switch lines.
REQ-009 mode  input  2*N_CH  per-channel detect mode, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-010 db_len  input  DB_W  shared debounce length D, applied to all channels.
REQ-011 clr_flags  input  1  synchronous clear of all sticky flags.
REQ-012 clr_count  input  1  synchronous clear of all event counters.
REQ-013 stable  output  N_CH  debounced level per channel.
REQ-014 edge_pulse  output  N_CH  registered one-cycle pulse per qualified edge.
REQ-015 flag  output  N_CH  sticky per-channel event flag.
REQ-016 event_cnt  output  N_CH*CNT_W  per-channel saturating event count, channel i at bits [(i+1)*CNT_W-1:i*CNT_W].
REQ-017 any_event  output  1  registered OR of edge_pulse sources; high in the same cycles as any edge_pulse bit.

Function
REQ-018 Each channel SHALL pass sig_in through a SYNC_STAGES-deep flop chain; the last stage is the synced level s.
REQ-019 Each channel SHALL keep a debounce counter of DB_W bits:
  - s == stable: counter <= 0.
  - s != stable and counter != D: counter <= counter + 1.
  - s != stable and counter == D: stable <= s, counter <= 0.
REQ-020 With D = 0, stable SHALL update on the first edge at which s differs from it.
REQ-021 Any return of s to the stable value before the counter reaches D SHALL reset the counter and SHALL NOT change stable (glitch rejection).
REQ-022 End-to-end latency from a sig_in change, held steady, to stable changing SHALL be SYNC_STAGES + D + 1 clk edges.
REQ-023 Qualified edge: a stable change matching mode (01 rise 0->1, 10 fall 1->0, 11 either, 00 none).
REQ-024 edge_pulse[i] SHALL be set on the same clk edge that stable[i] changes on a qualified edge, and SHALL clear on the next edge (exactly one cycle high).
REQ-025 A change of mode SHALL NOT by itself generate a pulse; the new mode SHALL apply from the next stable transition.
REQ-026 flag[i] SHALL set on any qualified edge and hold until clr_flags; when clr_flags and a qualified edge coincide, flag[i] SHALL end high.
REQ-027 event_cnt[i] SHALL increment by 1 on each qualified edge and saturate at 2^CNT_W-1 without wrapping.
REQ-028 clr_count SHALL take priority over a coincident increment; the counter SHALL read 0 afterwards.
REQ-029 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be pulsed, flagged and counted in the same cycle.

Reset
REQ-030 While reset is high, all of the following SHALL hold regardless of clk:
  - sync chains and stable = IDLE_LEVEL.
  - debounce counters = 0.
  - edge_pulse = 0, flag = 0, event_cnt = 0, any_event = 0.
REQ-031 Reset asserted mid-debounce or mid-pulse SHALL abort the operation with no residual pulse after release.
REQ-032 After reset release, an input equal to IDLE_LEVEL SHALL generate no edge.

Verification
REQ-033 The bench SHALL cover these scenarios (N_CH=4, SYNC_STAGES=2, CNT_W=8, IDLE_LEVEL=1):
  - Ch0 mode 10, D=3, sig_in[0] 1->0 held -> stable[0] falls 6 edges later; edge_pulse[0] and any_event high 1 cycle; event_cnt ch0 = 1; flag[0] = 1.
  - Ch1 mode 10, D=3, 3-cycle low glitch on sig_in[1] -> stable[1] stays 1; no pulse; count stays 0.
  - Ch2 mode 11, D=0, toggle sig_in[2] every 4 cycles for 300 toggles -> pulse per toggle; event_cnt ch2 saturates at 255.
  - Ch3 mode 01, falling edge -> no pulse; then mode 01 with rising edge coinciding with clr_flags -> flag[3] = 1, count = 1.
  - Ch0 and ch1 edges in the same cycle with clr_count asserted -> both pulse, both counts read 0.
  - Reset asserted 2 cycles into a D=5 debounce -> all outputs 0 or IDLE_LEVEL immediately; no pulse after release.
